shift_count_register: RTL
=========================

Name: shift_count_register

Overview:
- Parametrised next-generation general-purpose datapath register for the PicoComputer CPU.
- Keeps the established command set: clear, load, increment, decrement, shift right and shift left.
- Adds:
  - generic width;
  - multi-bit shifts, executed one bit per clock under a busy/done handshake;
  - four shift modes;
  - a carry flag;
  - zero and negative status outputs for the control unit.

Parameters:
- WIDTH, 8, data width in bits (≥2).
- SHW, 3, shift-amount field width; maximum shift count is 2**SHW-1.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- cl  input  1  clear command
- ld  input  1  load command
- in  input  WIDTH  load data
- inc  input  1  increment command
- dec  input  1  decrement command
- sr  input  1  shift-right command
- ir  input  1  serial input bit for logical shift right
- sl  input  1  shift-left command
- il  input  1  serial input bit for logical shift left
- mode  input  2  shift mode: 00 logical, 01 arithmetic, 10 rotate, 11 rotate-through-carry
- shamt  input  SHW  shift count; 0 is treated as 1
- out  output  WIDTH  register contents
- carry  output  1  carry/borrow/last-shifted-out bit
- zero  output  1  out == 0 (combinational)
- neg  output  1  out[WIDTH-1] (combinational)
- busy  output  1  multi-cycle shift in progress
- done  output  1  one-cycle pulse: shift complete

Behaviour:
- Reset (async, rst_n low):
  - out=0, carry=0, busy=0, done=0, state=IDLE, remaining count=0.
  - Takes effect immediately, including mid-shift.
- States: IDLE, SHIFT. busy = (state==SHIFT), registered.
- Command priority in IDLE: cl > ld > inc > dec > sr > sl. With no command asserted, out and carry hold.
  - cl: out<=0; carry<=0.
  - ld: out<=in; carry unchanged.
  - inc: {carry,out}<=out+1, computed at WIDTH+1 bits. 0xFF->0x00 sets carry=1.
  - dec: out<=out-1 (modulo 2**WIDTH); carry<=(out==0), i.e. borrow.
- Shift start (sr or sl in IDLE):
  - Latch the direction, mode, ir and il.
  - N = (shamt==0) ? 1 : shamt.
  - The first bit is shifted on the command edge.
  - If N==1: stay IDLE; done=1 in the following cycle.
  - Otherwise: enter SHIFT with remaining=N-1.
- SHIFT state:
  - One bit is shifted per clock, and remaining decrements.
  - On the edge that performs the final bit: state<=IDLE and done<=1 for exactly one cycle.
  - A shift of N bits therefore holds busy high for N-1 cycles; done coincides with out holding its final value.
- Per-bit shift rules. b = the bit leaving out; carry<=b in every mode.
  - Logical: sr fills the MSB with the latched ir; sl fills the LSB with the latched il.
  - Arithmetic: sr fills with out[WIDTH-1] (sign replicated); sl fills with 0, and il is ignored.
  - Rotate: the fill bit is b.
  - Rotate-through-carry: the fill bit is the current carry, and carry<=b.
- During SHIFT:
  - ld, inc, dec, sr and sl are ignored. They are not queued.
  - cl aborts the shift: out<=0, carry<=0, state<=IDLE. busy is 0 from the next cycle, and no done pulse is produced.
- Changing shamt, mode, ir or il during SHIFT has no effect.
- done is never asserted in the same cycle as busy except for the final-bit transition. On that edge busy falls and done rises.

Test Plan (WIDTH=8, SHW=3):
- Reset, then ld in=0xA5 -> out=0xA5, zero=0, neg=1, carry=0.
- ld 0xFF, then inc -> out=0x00, carry=1, zero=1; then dec -> out=0xFF, carry=1. Then dec -> out=0xFE, carry=0.
- ld 0xA5, then sr with mode=00, ir=1, shamt=3 -> busy high for 2 cycles, done pulse on the 3rd edge, out=0xF4, carry=1. Intermediate values are 0xD2 and 0xE9.
- Shift modes:
  - sr mode=01, shamt=2 on 0x80 -> 0xE0.
  - sl mode=10, shamt=4 on 0x3C -> 0xC3.
  - With carry=0, sl mode=11, shamt=1 on 0x81 -> out=0x02, carry=1, done after 1 cycle, busy never high.
- ld 0x01, then sl mode=00, il=0, shamt=5. Assert ld 0x55 during busy -> ignored. Then assert cl after 2 edges -> out=0x00, carry=0, busy=0 next cycle, no done pulse.
- Start sr shamt=7 on 0xFF, then pulse rst_n low mid-shift -> out=0, carry=0, busy=0, done=0 immediately. After release, the register is in IDLE and accepts ld.

Source files
------------

// File: rtl/shift_count_register.sv
// General-purpose datapath register: clear/load/inc/dec plus multi-bit shifts
// executed one bit per clock, with a busy/done handshake and carry/zero/neg flags.
module shift_count_register #(
    parameter int WIDTH = 8,
    parameter int SHW   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cl,
    input  logic             ld,
    input  logic [WIDTH-1:0] in,
    input  logic             inc,
    input  logic             dec,
    input  logic             sr,
    input  logic             ir,
    input  logic             sl,
    input  logic             il,
    input  logic [1:0]       mode,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             carry_q, carry_d;
    logic             done_q, done_d;
    logic [SHW-1:0]   rem_q, rem_d;
    logic             left_q, left_d;
    logic [1:0]       mode_q, mode_d;
    logic             ir_q, ir_d;
    logic             il_q, il_d;

    // One-bit shift step; returns {new_carry, new_value}.
    function automatic logic [WIDTH:0] shift_bit(
        input logic [WIDTH-1:0] v,
        input logic             c,
        input logic             left,
        input logic [1:0]       m,
        input logic             fir,
        input logic             fil
    );
        logic b;
        logic fill;
        logic [WIDTH:0] r;
        b    = 1'b0;
        fill = 1'b0;
        r    = '0;
        if (left) begin
            b = v[WIDTH-1];
            case (m)
                2'b00:   fill = fil;
                2'b01:   fill = 1'b0;
                2'b10:   fill = b;
                default: fill = c;
            endcase
            r = {b, v[WIDTH-2:0], fill};
        end else begin
            b = v[0];
            case (m)
                2'b00:   fill = fir;
                2'b01:   fill = v[WIDTH-1];
                2'b10:   fill = b;
                default: fill = c;
            endcase
            r = {b, fill, v[WIDTH-1:1]};
        end
        return r;
    endfunction

    logic [WIDTH:0] sh_start;
    logic [WIDTH:0] sh_cont;
    logic [WIDTH:0] inc_sum;

    // sr outranks sl, so a start shifts left only when sr is low.
    assign sh_start = shift_bit(out_q, carry_q, ~sr, mode, ir, il);
    assign sh_cont  = shift_bit(out_q, carry_q, left_q, mode_q, ir_q, il_q);
    assign inc_sum  = {1'b0, out_q} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        rem_d   = rem_q;
        left_d  = left_q;
        mode_d  = mode_q;
        ir_d    = ir_q;
        il_d    = il_q;
        case (state_q)
            IDLE: begin
                if (cl) begin
                    out_d   = '0;
                    carry_d = 1'b0;
                end else if (ld) begin
                    out_d = in;
                end else if (inc) begin
                    {carry_d, out_d} = inc_sum;
                end else if (dec) begin
                    out_d   = out_q - {{(WIDTH-1){1'b0}}, 1'b1};
                    carry_d = (out_q == '0);
                end else if (sr || sl) begin
                    left_d           = ~sr;
                    mode_d           = mode;
                    ir_d             = ir;
                    il_d             = il;
                    {carry_d, out_d} = sh_start;
                    if (shamt <= {{(SHW-1){1'b0}}, 1'b1}) begin
                        done_d = 1'b1;
                        rem_d  = '0;
                    end else begin
                        state_d = SHIFT;
                        rem_d   = shamt - {{(SHW-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: begin
                if (cl) begin
                    out_d   = '0;
                    carry_d = 1'b0;
                    rem_d   = '0;
                    state_d = IDLE;
                end else begin
                    {carry_d, out_d} = sh_cont;
                    rem_d            = rem_q - {{(SHW-1){1'b0}}, 1'b1};
                    if (rem_q == {{(SHW-1){1'b0}}, 1'b1}) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= '0;
            left_q  <= 1'b0;
            mode_q  <= 2'b00;
            ir_q    <= 1'b0;
            il_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            done_q  <= done_d;
            rem_q   <= rem_d;
            left_q  <= left_d;
            mode_q  <= mode_d;
            ir_q    <= ir_d;
            il_q    <= il_d;
        end
    end

    assign out   = out_q;
    assign carry = carry_q;
    assign zero  = (out_q == '0);
    assign neg   = out_q[WIDTH-1];
    assign busy  = (state_q == SHIFT);
    assign done  = done_q;

endmodule
